// File: rtl/smg_pkg.sv
// Shared constants for the 7-segment scan decoder: segment codes, strobe patterns, FSM states.
package smg_pkg;

    // Active-high gfedcba codes for hex digits 0..F
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [3:0] SCAN_D0 = 4'b1000;
    localparam logic [3:0] SCAN_D1 = 4'b0100;
    localparam logic [3:0] SCAN_D2 = 4'b0010;
    localparam logic [3:0] SCAN_D3 = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_e;

    // Returns {is_one_hot, slot}; slot 0 is the leftmost digit
    function automatic logic [2:0] scan_slot(input logic [3:0] s);
        case (s)
            SCAN_D0: return 3'b100;
            SCAN_D1: return 3'b101;
            SCAN_D2: return 3'b110;
            SCAN_D3: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/smg_scan_decoder_seg_decode.sv
// Combinational hex-table lookup: active-high gfedcba code to nibble plus legality flag.
import smg_pkg::*;

module smg_seg_decode (
    input  logic [6:0] code_i,
    output logic [3:0] nib_o,
    output logic       vld_o
);

    always_comb begin
        nib_o = 4'h0;
        vld_o = 1'b1;
        case (code_i)
            SEG_0:   nib_o = 4'h0;
            SEG_1:   nib_o = 4'h1;
            SEG_2:   nib_o = 4'h2;
            SEG_3:   nib_o = 4'h3;
            SEG_4:   nib_o = 4'h4;
            SEG_5:   nib_o = 4'h5;
            SEG_6:   nib_o = 4'h6;
            SEG_7:   nib_o = 4'h7;
            SEG_8:   nib_o = 4'h8;
            SEG_9:   nib_o = 4'h9;
            SEG_A:   nib_o = 4'hA;
            SEG_B:   nib_o = 4'hB;
            SEG_C:   nib_o = 4'hC;
            SEG_D:   nib_o = 4'hD;
            SEG_E:   nib_o = 4'hE;
            SEG_F:   nib_o = 4'hF;
            default: vld_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/smg_scan_decoder.sv
// Rebuilds four hex digits + decimal points from a multiplexed 7-segment bus and
// publishes one validated value per complete, in-order scan frame.
import smg_pkg::*;

module smg_scan_decoder #(
    parameter int SETTLE         = 8,
    parameter int TIMEOUT        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [3:0]  Scan_Sig,
    input  logic [7:0]  SMG_Data,
    output logic [15:0] Digit_Value,
    output logic [3:0]  Digit_DP,
    output logic        Frame_Valid,
    output logic        Bad_Frame,
    output logic        Link_Up
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [19:0] IDLE_MAX    = 20'(TIMEOUT);

    logic [3:0]       scan_m_q, scan_s_q, scan_p_q;
    logic [7:0]       seg_m_q, seg_s_q, seg_n;
    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [19:0]      idle_q, idle_d;
    logic [1:0]       exp_q, exp_d, sl;
    logic             bad_q, bad_d, bad_cur, sl_ok, change;
    logic [3:0][3:0]  nib_q, nib_d;
    logic [3:0]       dpb_q, dpb_d, dp_q, dp_d;
    logic [15:0]      val_q, val_d;
    logic             fv_q, fv_d, bf_q, bf_d, link_q, link_d;
    logic [3:0]       dec_nib;
    logic             dec_vld;

    assign seg_n  = SEG_ACTIVE_LOW ? ~seg_s_q : seg_s_q;
    assign change = (scan_s_q != scan_p_q);
    // scan_p_q holds the settled pattern while in SETTLE-complete and SAMPLE
    assign {sl_ok, sl} = scan_slot(scan_p_q);

    smg_seg_decode u_dec (
        .code_i (seg_n[6:0]),
        .nib_o  (dec_nib),
        .vld_o  (dec_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        exp_d   = exp_q;
        bad_d   = bad_q;
        bad_cur = 1'b0;
        nib_d   = nib_q;
        dpb_d   = dpb_q;
        val_d   = val_q;
        dp_d    = dp_q;
        fv_d    = 1'b0;
        bf_d    = 1'b0;
        link_d  = link_q;

        if (change) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = sl_ok ? ST_SAMPLE : ST_HOLD;
                        // Settled non-one-hot, non-blank pattern: sequence error
                        if (!sl_ok && scan_p_q != 4'b0000) begin
                            bf_d  = ~bad_q;
                            bad_d = 1'b1;
                            exp_d = 2'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_SAMPLE: state_d = ST_HOLD;
                default:   state_d = state_q;
            endcase
        end

        if (change) begin
            idle_d = 20'd0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 20'd1;
        end
        if (!change && idle_q == IDLE_MAX - 20'd1) begin
            link_d = 1'b0;
            exp_d  = 2'd0;
            bad_d  = 1'b0;
        end

        if (state_q == ST_SAMPLE) begin
            nib_d[2'd3 - sl] = dec_nib;
            dpb_d[2'd3 - sl] = seg_n[7];
            if (sl == exp_q) begin
                // Slot 0 opens a fresh frame, so earlier badness is forgotten
                bad_cur = bad_q & (sl != 2'd0);
                bf_d    = ~dec_vld & ~bad_cur;
                bad_d   = bad_cur | ~dec_vld;
                exp_d   = exp_q + 2'd1;
                if (sl == 2'd3) begin
                    bad_d = 1'b0;
                    if (!bad_cur && dec_vld) begin
                        val_d  = nib_d;
                        dp_d   = dpb_d;
                        fv_d   = 1'b1;
                        link_d = 1'b1;
                    end
                end
            end else begin
                bf_d = ~bad_q | ((sl == 2'd0) & ~dec_vld);
                if (sl == 2'd0) begin
                    exp_d = 2'd1;
                    bad_d = ~dec_vld;
                end else begin
                    exp_d = 2'd0;
                    bad_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            scan_m_q <= 4'h0;
            scan_s_q <= 4'h0;
            scan_p_q <= 4'h0;
            seg_m_q  <= 8'h00;
            seg_s_q  <= 8'h00;
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            idle_q   <= 20'd0;
            exp_q    <= 2'd0;
            bad_q    <= 1'b0;
            nib_q    <= '0;
            dpb_q    <= 4'h0;
            val_q    <= 16'h0000;
            dp_q     <= 4'h0;
            fv_q     <= 1'b0;
            bf_q     <= 1'b0;
            link_q   <= 1'b0;
        end else begin
            scan_m_q <= Scan_Sig;
            scan_s_q <= scan_m_q;
            scan_p_q <= scan_s_q;
            seg_m_q  <= SMG_Data;
            seg_s_q  <= seg_m_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            exp_q    <= exp_d;
            bad_q    <= bad_d;
            nib_q    <= nib_d;
            dpb_q    <= dpb_d;
            val_q    <= val_d;
            dp_q     <= dp_d;
            fv_q     <= fv_d;
            bf_q     <= bf_d;
            link_q   <= link_d;
        end
    end

    assign Digit_Value = val_q;
    assign Digit_DP    = dp_q;
    assign Frame_Valid = fv_q;
    assign Bad_Frame   = bf_q;
    assign Link_Up     = link_q;

endmodule

// File: doc/smg_scan_decoder.md
# smg_scan_decoder

Receive-side counterpart of the 4-digit 7-segment scan driver. Watches an externally multiplexed display bus: a one-hot digit strobe plus 8 segment lines. From those lines it rebuilds the four displayed hex digits and their decimal points. Sits between board pins (or the scan/segment outputs of another board) and internal logic, and delivers a validated 16-bit value once per complete scan frame.

## Interface
- SETTLE, 8: cycles a new strobe pattern must stay stable (post-synchronizer) before segments are sampled; range 1..255.
- TIMEOUT, 50000: cycles without an accepted strobe change before the link is declared down; range 1..2^20-1.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when line is 0 (common anode); 0 = lit when 1.
- CLK  input  1  system clock; one clock domain.
- RSTn  input  1  reset, asynchronous assert, active-low.
- Scan_Sig  input  4  digit strobe, asynchronous to CLK; 4'b1000 = digit 0 (leftmost), 4'b0100 = digit 1, 4'b0010 = digit 2, 4'b0001 = digit 3.
- SMG_Data  input  8  segment lines {dp,g,f,e,d,c,b,a}, asynchronous to CLK.
- Digit_Value  output  16  last good frame; [15:12] = digit 0 … [3:0] = digit 3.
- Digit_DP  output  4  decimal points of last good frame; bit 3 = digit 0.
- Frame_Valid  output  1  one-cycle pulse when Digit_Value/Digit_DP update.
- Bad_Frame  output  1  one-cycle pulse when a frame is discarded.
- Link_Up  output  1  level; 1 after first good frame, 0 after timeout.

## Operation
- Both input buses pass through 2-flop synchronizers; all logic below works on the synchronized copies (scan_s, seg_s). Segments are normalized to active-high when SEG_ACTIVE_LOW=1.
- Change detect: scan_s != previous scan_s restarts the settle counter with the new pattern.
- States: IDLE, SETTLE, SAMPLE, HOLD.
  - IDLE → SETTLE on any change.
  - SETTLE → SAMPLE when the counter reaches SETTLE with the pattern unchanged. Any change during SETTLE restarts SETTLE.
  - SAMPLE (1 cycle) → HOLD.
  - HOLD → SETTLE on the next change.
- Pattern 4'b0000 is inter-digit blanking. It settles but is never sampled and is not an error.
- Any other non-one-hot pattern (e.g. 4'b1100) counts as a sequence error.
- SAMPLE:
  - Decode seg_s[6:0] through the hex table: 0–9, A, b, C, d, E, F (active-high gfedcba codes 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71).
  - Any other code, including blank 00, is a digit error.
  - Write the nibble and seg_s[7] into the slot given by the strobe.
- Sequence tracking:
  - An expected-slot index starts at 0.
  - A sampled slot equal to the expected slot advances the index.
  - A mismatch, or a sequence error, marks the current frame bad. The index then resyncs: it becomes 1 if the offending strobe was 4'b1000, else 0.
- Frame end: after slot 3 is sampled as expected, check the frame.
  - Clean frame (4 in-order slots, no digit error): the outputs update and Frame_Valid pulses.
  - Otherwise: Bad_Frame pulses and the outputs hold.
- Bad_Frame pulses at most once per frame. Its trigger is the frame's first error, or the end of a bad frame, whichever comes first.
- Timeout: an idle counter clears on every change and saturates at TIMEOUT. On reaching TIMEOUT:
  - Link_Up drops to 0.
  - The index and bad flag reset.
  - A partial frame is discarded silently.
- Link_Up returns to 1 with the next Frame_Valid.
- Simultaneous change and timeout in the same cycle: the change wins.

## Timing
- Reset values: Digit_Value 16'h0000, Digit_DP 4'h0, Frame_Valid 0, Bad_Frame 0, Link_Up 0. The FSM resets to IDLE with index 0 and all counters 0.
- Input to scan_s: 2 cycles.
- scan_s change to SAMPLE: SETTLE+1 cycles.
- Frame_Valid/Bad_Frame: registered, asserted the cycle after the slot-3 SAMPLE. Digit_Value and Digit_DP change on that same edge.
- Reset asserted mid-frame: immediate return to reset values. The first frame after reset needs a fresh 4'b1000.
- Each strobe interval gives exactly one sample, however long the strobe stays stable.

## Structure
- Package smg_pkg holds:
  - 7-bit segment code constants for 0–F.
  - FSM state encoding.
  - Strobe constants SCAN_D0..SCAN_D3 (4'b1000..4'b0001).
- The hex-table decode lives in sub-module smg_seg_decode: combinational, 7-bit code in, 4-bit nibble plus a valid flag out. All sequencing stays in the top module.

## Test plan
- Clean frame: drive 1000/0100/0010/0001 with segments 06,5B,4F,66 (active-high logical, inverted on pins), each held 20 cycles, SETTLE=8 → one Frame_Valid, Digit_Value=16'h1234, Link_Up=1.
- Glitch: insert a 3-cycle 4'b0100 spike during digit 0 → settle restarts with no sample, and the frame still yields 16'h1234. Add 4'b0000 blanking between digits → same result.
- Out of order: drive 1000, 0010, 0100, 0001 → Bad_Frame pulses once, outputs hold. The next clean 5678 frame gives Frame_Valid with 16'h5678.
- Illegal segment: digit 2 shows code 00 → Bad_Frame; Digit_Value keeps its previous value.
- Timeout: TIMEOUT=100, stop strobing after a good frame → Link_Up falls at cycle 100 after the last change. A 2-slot partial frame followed by silence gives no Bad_Frame.
- Reset mid-frame: assert RSTn low after slot 1 → all outputs 0 within one cycle. After release, a full frame A b C d with dp on digit 1 → 16'hABCD, Digit_DP=4'b0100.
